anita3_event_header_store: RTL and testbench

Downstream of the dual event generator on the 33 MHz side: captures the per-event header word stream (`event_addr`/`event_dat`/`event_wr`/`event_done`) into four 32×16 header buffers, one per digitizer buffer. It queues completed headers in completion order and serves them to the host readout logic through a registered read port. Each buffer stays held until the host acknowledges it.

---
 rtl/anita3_event_header_store.sv | 172 +++++++++++++++++
 tb/tb_anita3_event_header_store.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/anita3_event_header_store.sv
// Event header capture: four 32x16 header buffers, completion-ordered queue and registered host read port.
// Optional per-buffer running checksum on word 0x1F when EVENT_HEADER_CHECKSUM_EN is defined.
module anita3_event_header_store (
  input  logic        clk33_i,
  input  logic        rst_n_i,
  input  logic [7:0]  event_addr_i,
  input  logic [15:0] event_dat_i,
  input  logic        event_wr_i,
  input  logic        event_done_i,
  input  logic        rd_req_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        ack_i,
  input  logic        clear_i,
  output logic [15:0] rd_dat_o,
  output logic        rd_valid_o,
  output logic        ready_o,
  output logic [1:0]  head_buf_o,
  output logic [2:0]  pending_o,
  output logic [3:0]  held_mask_o,
  output logic        overflow_o,
  output logic        addr_err_o
);

  logic [15:0] ram_r [0:127];
  logic [1:0]  q_r [0:3];
  logic [1:0]  wp_r, rp_r;
  logic [2:0]  cnt_r, cnt_nxt_s;
  logic [3:0]  held_r, held_nxt_s;
  logic        overflow_r, addr_err_r;
  logic [15:0] rd_dat_r, rd_word_s;
  logic        rd_valid_r;
  logic [1:0]  evt_buf_s, head_s;
  logic        wr_ok_s, done_ok_s, ack_ok_s, ovf_hit_s, aerr_hit_s;

`ifdef EVENT_HEADER_CHECKSUM_EN
  logic [15:0] sum_r [0:3];

  function automatic logic [15:0] sum16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0];
  endfunction
`endif

  // Acceptance decisions, all judged against the held mask from before this cycle
  always_comb begin
    evt_buf_s  = event_addr_i[7:6];
    head_s     = q_r[rp_r];
    wr_ok_s    = event_wr_i & ~event_addr_i[5] & ~held_r[evt_buf_s];
    done_ok_s  = event_done_i & ~held_r[evt_buf_s];
    ack_ok_s   = ack_i & (cnt_r != 3'd0);
    ovf_hit_s  = (event_done_i | event_wr_i) & held_r[evt_buf_s];
    aerr_hit_s = event_wr_i & event_addr_i[5];
  end

  // Next held mask and queue occupancy; an acked head is always held, so it never equals an accepted done
  always_comb begin
    held_nxt_s = held_r;
    cnt_nxt_s  = cnt_r;
    if (clear_i) begin
      held_nxt_s = 4'b0000;
      cnt_nxt_s  = 3'd0;
    end else begin
      if (ack_ok_s) begin
        held_nxt_s[head_s] = 1'b0;
      end else begin
        held_nxt_s = held_r;
      end
      if (done_ok_s) begin
        held_nxt_s[evt_buf_s] = 1'b1;
      end else begin
        held_nxt_s[evt_buf_s] = held_nxt_s[evt_buf_s];
      end
      case ({done_ok_s, ack_ok_s})
        2'b10:   cnt_nxt_s = cnt_r + 3'd1;
        2'b01:   cnt_nxt_s = cnt_r - 3'd1;
        default: cnt_nxt_s = cnt_r;
      endcase
    end
  end

  // Read data selection; an empty queue reads as zero
  always_comb begin
    rd_word_s = ram_r[{head_s, rd_addr_i}];
    if (cnt_r == 3'd0) begin
      rd_word_s = 16'h0000;
`ifdef EVENT_HEADER_CHECKSUM_EN
    end else if (rd_addr_i == 5'h1F) begin
      rd_word_s = sum_r[head_s];
`endif
    end else begin
      rd_word_s = ram_r[{head_s, rd_addr_i}];
    end
  end

  // Header RAM, uninitialised
  always_ff @(posedge clk33_i) begin
    if (wr_ok_s) ram_r[{evt_buf_s, event_addr_i[4:0]}] <= event_dat_i;
  end

  // Completion queue, held mask and sticky error flags
  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 4; i++) q_r[i] <= 2'd0;
      wp_r       <= 2'd0;
      rp_r       <= 2'd0;
      cnt_r      <= 3'd0;
      held_r     <= 4'b0000;
      overflow_r <= 1'b0;
      addr_err_r <= 1'b0;
    end else if (clear_i) begin
      wp_r       <= 2'd0;
      rp_r       <= 2'd0;
      cnt_r      <= 3'd0;
      held_r     <= 4'b0000;
      overflow_r <= 1'b0;
      addr_err_r <= 1'b0;
    end else begin
      if (done_ok_s) begin
        q_r[wp_r] <= evt_buf_s;
        wp_r      <= wp_r + 2'd1;
      end
      if (ack_ok_s) rp_r <= rp_r + 2'd1;
      cnt_r      <= cnt_nxt_s;
      held_r     <= held_nxt_s;
      overflow_r <= overflow_r | ovf_hit_s;
      addr_err_r <= addr_err_r | aerr_hit_s;
    end
  end

  // Registered read port; data holds between reads
  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_dat_r   <= 16'h0000;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_req_i;
      if (rd_req_i) rd_dat_r <= rd_word_s;
    end
  end

`ifdef EVENT_HEADER_CHECKSUM_EN
  // Running sums; a released buffer restarts from zero
  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 4; i++) sum_r[i] <= 16'h0000;
    end else if (clear_i) begin
      for (int i = 0; i < 4; i++) sum_r[i] <= 16'h0000;
    end else begin
      if (ack_ok_s) sum_r[head_s] <= 16'h0000;
      if (wr_ok_s) sum_r[evt_buf_s] <= sum16(sum_r[evt_buf_s], event_dat_i);
    end
  end
`endif

  // Output mapping from registered state
  always_comb begin
    rd_dat_o    = rd_dat_r;
    rd_valid_o  = rd_valid_r;
    ready_o     = (cnt_r != 3'd0);
    pending_o   = cnt_r;
    held_mask_o = held_r;
    overflow_o  = overflow_r;
    addr_err_o  = addr_err_r;
    if (cnt_r != 3'd0) begin
      head_buf_o = q_r[rp_r];
    end else begin
      head_buf_o = 2'd0;
    end
  end

endmodule

// File: tb/tb_anita3_event_header_store.sv
// Table-driven bench for anita3_event_header_store with a read-data scoreboard.
// Checksum expectations follow EVENT_HEADER_CHECKSUM_EN.
module tb_anita3_event_header_store;

  logic        clk33_i = 1'b0;
  logic        rst_n_i;
  logic [7:0]  event_addr_i;
  logic [15:0] event_dat_i;
  logic        event_wr_i, event_done_i, rd_req_i, ack_i, clear_i;
  logic [4:0]  rd_addr_i;
  logic [15:0] rd_dat_o;
  logic        rd_valid_o, ready_o, overflow_o, addr_err_o;
  logic [1:0]  head_buf_o;
  logic [2:0]  pending_o;
  logic [3:0]  held_mask_o;

  anita3_event_header_store dut (
    .clk33_i(clk33_i), .rst_n_i(rst_n_i), .event_addr_i(event_addr_i),
    .event_dat_i(event_dat_i), .event_wr_i(event_wr_i), .event_done_i(event_done_i),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .ack_i(ack_i), .clear_i(clear_i),
    .rd_dat_o(rd_dat_o), .rd_valid_o(rd_valid_o), .ready_o(ready_o),
    .head_buf_o(head_buf_o), .pending_o(pending_o), .held_mask_o(held_mask_o),
    .overflow_o(overflow_o), .addr_err_o(addr_err_o)
  );

  always #5 clk33_i = ~clk33_i;

  typedef struct {
    logic        wr, done, ack, clr, rd;
    logic [7:0]  ea;
    logic [15:0] ed;
    logic [4:0]  ra;
    logic [15:0] exp_rd;
    logic [2:0]  pend;
    logic [3:0]  held;
    logic [1:0]  head;
    logic        ovf, aerr;
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] sb[$];
  int          checks = 0;
  int          failures = 0;

`ifdef EVENT_HEADER_CHECKSUM_EN
  localparam logic [15:0] SUM_A = 16'h0006;
  localparam logic [15:0] SUM_B = 16'h0001;
`else
  localparam logic [15:0] SUM_A = 16'h8000;
  localparam logic [15:0] SUM_B = 16'h8000;
`endif

  function automatic vec_t v(input logic [4:0] ctl, input logic [7:0] ea, input logic [15:0] ed,
                             input logic [4:0] ra, input logic [15:0] exp_rd, input logic [2:0] pend,
                             input logic [3:0] held, input logic [1:0] head, input logic ovf,
                             input logic aerr);
    vec_t r;
    {r.wr, r.done, r.ack, r.clr, r.rd} = ctl;
    r.ea = ea; r.ed = ed; r.ra = ra; r.exp_rd = exp_rd;
    r.pend = pend; r.held = held; r.head = head; r.ovf = ovf; r.aerr = aerr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    event_addr_i = 8'h00; event_dat_i = 16'h0000; event_wr_i = 1'b0; event_done_i = 1'b0;
    rd_req_i = 1'b0; rd_addr_i = 5'h00; ack_i = 1'b0; clear_i = 1'b0;
  endtask

  task automatic check_state(input string tag, input vec_t r);
    logic [15:0] e;
    chk({tag, ".pending"}, {13'd0, pending_o}, {13'd0, r.pend});
    chk({tag, ".held"}, {12'd0, held_mask_o}, {12'd0, r.held});
    chk({tag, ".ready"}, {15'd0, ready_o}, {15'd0, (r.pend != 3'd0)});
    chk({tag, ".head"}, {14'd0, head_buf_o}, {14'd0, r.head});
    chk({tag, ".overflow"}, {15'd0, overflow_o}, {15'd0, r.ovf});
    chk({tag, ".addr_err"}, {15'd0, addr_err_o}, {15'd0, r.aerr});
    chk({tag, ".rd_valid"}, {15'd0, rd_valid_o}, {15'd0, r.rd});
    if (rd_valid_o) begin
      if (sb.size() == 0) begin
        chk({tag, ".rd_unexpected"}, 16'd1, 16'd0);
      end else begin
        e = sb.pop_front();
        chk({tag, ".rd_dat"}, rd_dat_o, e);
      end
    end
  endtask

  task automatic step(input int idx, input vec_t r);
    event_wr_i = r.wr; event_done_i = r.done; ack_i = r.ack; clear_i = r.clr;
    rd_req_i = r.rd; event_addr_i = r.ea; event_dat_i = r.ed; rd_addr_i = r.ra;
    if (r.rd) sb.push_back(r.exp_rd);
    @(posedge clk33_i);
    #1;
    idle_inputs();
    check_state($sformatf("v%0d", idx), r);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".rd_dat"}, rd_dat_o, 16'h0000);
    chk({tag, ".rd_valid"}, {15'd0, rd_valid_o}, 16'd0);
    chk({tag, ".ready"}, {15'd0, ready_o}, 16'd0);
    chk({tag, ".head"}, {14'd0, head_buf_o}, 16'd0);
    chk({tag, ".pending"}, {13'd0, pending_o}, 16'd0);
    chk({tag, ".held"}, {12'd0, held_mask_o}, 16'd0);
    chk({tag, ".overflow"}, {15'd0, overflow_o}, 16'd0);
    chk({tag, ".addr_err"}, {15'd0, addr_err_o}, 16'd0);
  endtask

  // ctl bits: {wr, done, ack, clr, rd}
  initial begin
    vec_t r;
    idle_inputs();
    rst_n_i = 1'b0;
    repeat (3) @(posedge clk33_i);
    #1;
    check_all_zero("reset");
    @(negedge clk33_i);
    rst_n_i = 1'b1;
    @(posedge clk33_i);
    #1;

    // basic capture on buf 2
    tbl.push_back(v(5'b10000, 8'h90, 16'h1234, 5'h00, 16'h0000, 3'd0, 4'b0000, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(5'b10000, 8'h91, 16'hABCD, 5'h00, 16'h0000, 3'd0, 4'b0000, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(5'b11000, 8'h80, 16'h00F5, 5'h00, 16'h0000, 3'd1, 4'b0100, 2'd2, 1'b0, 1'b0));
    tbl.push_back(v(5'b00001, 8'h00, 16'h0000, 5'h10, 16'h1234, 3'd1, 4'b0100, 2'd2, 1'b0, 1'b0));
    tbl.push_back(v(5'b00001, 8'h00, 16'h0000, 5'h11, 16'hABCD, 3'd1, 4'b0100, 2'd2, 1'b0, 1'b0));
    tbl.push_back(v(5'b00001, 8'h00, 16'h0000, 5'h00, 16'h00F5, 3'd1, 4'b0100, 2'd2, 1'b0, 1'b0));
    tbl.push_back(v(5'b00100, 8'h00, 16'h0000, 5'h00, 16'h0000, 3'd0, 4'b0000, 2'd0, 1'b0, 1'b0));
    // empty-queue read returns zero with a valid pulse
    tbl.push_back(v(5'b00001, 8'h00, 16'h0000, 5'h10, 16'h0000, 3'd0, 4'b0000, 2'd0, 1'b0, 1'b0));
    // ordering 1,3,0 with a pre-loaded word in buf 1
    tbl.push_back(v(5'b10000, 8'h44, 16'h5A5A, 5'h00, 16'h0000, 3'd0, 4'b0000, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(5'b01000, 8'h40, 16'h0000, 5'h00, 16'h0000, 3'd1, 4'b0010, 2'd1, 1'b0, 1'b0));
    tbl.push_back(v(5'b01000, 8'hC0, 16'h0000, 5'h00, 16'h0000, 3'd2, 4'b1010, 2'd1, 1'b0, 1'b0));
    tbl.push_back(v(5'b01000, 8'h00, 16'h0000, 5'h00, 16'h0000, 3'd3, 4'b1011, 2'd1, 1'b0, 1'b0));
    // overflow: done and write to held buf 1
    tbl.push_back(v(5'b01000, 8'h40, 16'h0000, 5'h00, 16'h0000, 3'd3, 4'b1011, 2'd1, 1'b1, 1'b0));
    tbl.push_back(v(5'b10000, 8'h44, 16'hFFFF, 5'h00, 16'h0000, 3'd3, 4'b1011, 2'd1, 1'b1, 1'b0));
    tbl.push_back(v(5'b00001, 8'h00, 16'h0000, 5'h04, 16'h5A5A, 3'd3, 4'b1011, 2'd1, 1'b1, 1'b0));
    tbl.push_back(v(5'b00100, 8'h00, 16'h0000, 5'h00, 16'h0000, 3'd2, 4'b1001, 2'd3, 1'b1, 1'b0));
    tbl.push_back(v(5'b00100, 8'h00, 16'h0000, 5'h00, 16'h0000, 3'd1, 4'b0001, 2'd0, 1'b1, 1'b0));
    // ack + done on another buffer, then on the head buffer itself, then ack when empty
    tbl.push_back(v(5'b01100, 8'h80, 16'h0000, 5'h00, 16'h0000, 3'd1, 4'b0100, 2'd2, 1'b1, 1'b0));
    tbl.push_back(v(5'b01100, 8'h80, 16'h0000, 5'h00, 16'h0000, 3'd0, 4'b0000, 2'd0, 1'b1, 1'b0));
    tbl.push_back(v(5'b00100, 8'h00, 16'h0000, 5'h00, 16'h0000, 3'd0, 4'b0000, 2'd0, 1'b1, 1'b0));
    // address error, clear, clear overriding a done
    tbl.push_back(v(5'b10000, 8'h25, 16'h1111, 5'h00, 16'h0000, 3'd0, 4'b0000, 2'd0, 1'b1, 1'b1));
    tbl.push_back(v(5'b00010, 8'h00, 16'h0000, 5'h00, 16'h0000, 3'd0, 4'b0000, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(5'b01000, 8'hC0, 16'h0000, 5'h00, 16'h0000, 3'd1, 4'b1000, 2'd3, 1'b0, 1'b0));
    tbl.push_back(v(5'b01010, 8'h40, 16'h0000, 5'h00, 16'h0000, 3'd0, 4'b0000, 2'd0, 1'b0, 1'b0));
    // word 0x1F: checksum or plain RAM depending on build
    tbl.push_back(v(5'b10000, 8'h1F, 16'h8000, 5'h00, 16'h0000, 3'd0, 4'b0000, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(5'b10000, 8'h01, 16'h8001, 5'h00, 16'h0000, 3'd0, 4'b0000, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(5'b11000, 8'h00, 16'h0005, 5'h00, 16'h0000, 3'd1, 4'b0001, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(5'b00001, 8'h00, 16'h0000, 5'h1F, SUM_A,    3'd1, 4'b0001, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(5'b00100, 8'h00, 16'h0000, 5'h00, 16'h0000, 3'd0, 4'b0000, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(5'b11000, 8'h05, 16'h0001, 5'h00, 16'h0000, 3'd1, 4'b0001, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(5'b00001, 8'h00, 16'h0000, 5'h1F, SUM_B,    3'd1, 4'b0001, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(5'b00001, 8'h00, 16'h0000, 5'h05, 16'h0001, 3'd1, 4'b0001, 2'd0, 1'b0, 1'b0));

    for (int i = 0; i < tbl.size(); i++) step(i, tbl[i]);

    // async reset in the middle of an event, with state and read data live
    event_wr_i = 1'b1; event_done_i = 1'b1; event_addr_i = 8'hC0; event_dat_i = 16'h7777;
    #3;
    rst_n_i = 1'b0;
    #1;
    check_all_zero("async_rst");
    idle_inputs();
    @(negedge clk33_i);
    rst_n_i = 1'b1;
    @(posedge clk33_i);
    #1;
    check_all_zero("post_rst");
    r = v(5'b01000, 8'h80, 16'h0000, 5'h00, 16'h0000, 3'd1, 4'b0100, 2'd2, 1'b0, 1'b0);
    step(100, r);

    chk("sb_drained", sb.size(), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
